// File: rtl/serial_subtractor_6.sv
// rtl/serial_subtractor_6.sv - bit-serial two's-complement subtractor, LSB first, start/busy/done handshake
module serial_subtractor_6 #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bo
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [IW-1:0]    idx;
  logic             br;

  logic             x;
  logic             y;
  logic             d;
  logic             br_n;
  logic [WIDTH-1:0] res_n;

  // Single full-subtractor cell applied to the current LSBs and the running borrow
  always_comb begin
    x     = a_sh[0];
    y     = b_sh[0];
    d     = x ^ y ^ br;
    br_n  = (~x & y) | (~(x ^ y) & br);
    res_n = {d, res_sh[WIDTH-1:1]};
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bo     <= 1'b0;
      idx    <= '0;
      br     <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= 1'b0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_n;
          br     <= br_n;
          if (idx == LAST_IDX) begin
            // Final bit: publish the assembled result and the last borrow together
            diff  <= res_n;
            bo    <= br_n;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          // Start is deliberately not sampled here; re-accept happens from IDLE only
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_6.sv
// tb/tb_serial_subtractor_6.sv - self-checking bench for serial_subtractor_6
module tb_serial_subtractor_6;

  localparam int W = 6;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bo;

  int checks;
  int failures;
  int done_count;

  serial_subtractor_6 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bo    (bo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every done pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (done === 1'b1) done_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic on the operands
  function automatic logic [W:0] model(input int unsigned av, input int unsigned bv);
    int unsigned dv;
    dv = (av - bv) & ((1 << W) - 1);
    return {(av < bv) ? 1'b1 : 1'b0, W'(dv)};
  endfunction

  // One full operation with cycle-exact handshake checks; returns to IDLE afterwards
  task automatic run_op(input int unsigned av, input int unsigned bv, input bit scramble);
    logic [W:0] exp;
    exp   = model(av, bv);
    a     = W'(av);
    b     = W'(bv);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= W; i++) begin
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("done_run", {31'd0, done}, 32'd0);
      if (scramble && i == 2) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      tick();
    end
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("result", {25'd0, bo, diff}, {25'd0, exp});
    tick();
    chk("done_clear", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int base;
    logic [W:0] exp;
    checks     = 0;
    failures   = 0;
    done_count = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // 1. reset and idle quiet period
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {26'd0, diff}, 32'd0);
    chk("rst_bo", {31'd0, bo}, 32'd0);
    base = done_count;
    for (int i = 0; i < 20; i++) tick();
    chk("idle_no_done", done_count - base, 32'd0);

    // 2. basic operation
    run_op(13, 5, 1'b0);
    chk("hold_diff", {26'd0, diff}, 32'd8);
    tick();
    chk("hold_bo", {31'd0, bo}, 32'd0);

    // 3. borrow and wrap-around corners
    run_op(5, 13, 1'b0);
    run_op(0, 63, 1'b0);
    run_op(0, 1, 1'b0);
    run_op(63, 63, 1'b0);
    run_op(63, 0, 1'b0);

    // randomized operations, inputs scrambled mid-run
    for (int i = 0; i < 20; i++) run_op($urandom_range(0, 63), $urandom_range(0, 63), 1'b1);

    // 4. start held high: one result every W+2 cycles, in-flight values unaffected
    a     = 6'd40;
    b     = 6'd2;
    start = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      for (int i = 1; i <= W; i++) begin
        chk("bb_busy", {31'd0, busy}, 32'd1);
        if (i == 2) begin
          a = W'($urandom);
          b = W'($urandom);
        end
        if (i == W) begin
          a = 6'd40;
          b = 6'd2;
        end
        tick();
      end
      chk("bb_done", {31'd0, done}, 32'd1);
      chk("bb_result", {25'd0, bo, diff}, {25'd0, 1'b0, 6'd38});
      tick();
      chk("bb_idle_busy", {31'd0, busy}, 32'd0);
      chk("bb_idle_done", {31'd0, done}, 32'd0);
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < W + 2; i++) tick();

    // 5. reset mid-RUN discards the operation
    a     = 6'd50;
    b     = 6'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    base = done_count;
    rst  = 1'b1;
    tick();
    rst  = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_diff", {26'd0, diff}, 32'd0);
    chk("midrst_bo", {31'd0, bo}, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("midrst_no_done", done_count - base, 32'd0);
    run_op(50, 7, 1'b0);

    // 6. exhaustive sweep
    base = done_count;
    for (int ai = 0; ai < 64; ai++) begin
      for (int bi = 0; bi < 64; bi++) begin
        exp   = model(ai, bi);
        a     = W'(ai);
        b     = W'(bi);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < W; i++) tick();
        chk("sweep", {24'd0, done, bo, diff}, {24'd0, 1'b1, exp});
        tick();
      end
    end
    chk("sweep_count", done_count - base, 32'd4096);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
